// File: rtl/lc_packet_sink.sv
// Receive endpoint for the local-controller ring: filters packets by destination, buffers payloads, tracks frames.
// Optional build macro LC_SINK_SEQ_CHECK_EN adds the seq_err payload-sequence checker.
module lc_packet_sink #(
  parameter int datawidth            = 16,
  parameter int address_vector_width = 4,
  parameter int packet_width         = 2 + 2*datawidth + address_vector_width,
  parameter int fifo_depth           = 8,
  parameter int len_width            = 10
) (
  input  logic                            CLK,
  input  logic                            reset_n,
  input  logic [packet_width-1:0]         packet_in,
  input  logic [address_vector_width-1:0] node_mask,
  input  logic                            scenario_update,
  output logic [2*datawidth-1:0]          out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(fifo_depth):0]     fifo_count,
  output logic                            frame_done,
  output logic [len_width-1:0]            frame_len,
  output logic                            overflow,
  output logic [len_width-1:0]            drop_count
`ifdef LC_SINK_SEQ_CHECK_EN
  ,output logic                           seq_err
`endif
);

  localparam int PW = 2*datawidth;
  localparam int AW = $clog2(fifo_depth);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  logic                            pkt_valid;
  logic                            pkt_last;
  logic [PW-1:0]                   pkt_payload;
  logic [address_vector_width-1:0] pkt_dest;
  logic                            hit, pop, push, drop, full;

  logic [PW-1:0] mem_q [fifo_depth];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;

  logic [0:0]           state_q, state_d;
  logic [len_width-1:0] len_cnt_q, len_cnt_d;
  logic [len_width-1:0] frame_len_q, frame_len_d;
  logic                 frame_done_q, frame_done_d;
  logic                 overflow_q, overflow_d;
  logic [len_width-1:0] drop_count_q, drop_count_d;

  assign pkt_valid   = packet_in[packet_width-1];
  assign pkt_last    = packet_in[packet_width-2];
  assign pkt_payload = packet_in[packet_width-3:address_vector_width];
  assign pkt_dest    = packet_in[address_vector_width-1:0];

  assign hit  = pkt_valid & (|(pkt_dest & node_mask));
  assign pop  = out_valid_q & out_ready;
  assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push = hit & (~full | pop) & ~scenario_update;
  assign drop = hit & full & ~pop & ~scenario_update;

  // The output register looks past a pop immediately but only sees entries written before this edge.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
    out_valid_d = (rd_ptr_d != wr_ptr_q);
    out_data_d  = mem_q[rd_ptr_d[AW-1:0]];
    if (scenario_update) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= pkt_payload;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Frame tracking counts every hit, including those dropped on overflow.
  always_comb begin
    state_d      = state_q;
    len_cnt_d    = len_cnt_q;
    frame_len_d  = frame_len_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q | drop;
    drop_count_d = drop_count_q;
    if (drop && drop_count_q != '1) drop_count_d = drop_count_q + len_width'(1);
    if (hit) begin
      if (state_q == IDLE) begin
        if (pkt_last) begin
          frame_done_d = 1'b1;
          frame_len_d  = len_width'(1);
        end else begin
          state_d   = RECV;
          len_cnt_d = len_width'(1);
        end
      end else begin
        if (pkt_last) begin
          frame_done_d = 1'b1;
          frame_len_d  = (len_cnt_q == '1) ? len_cnt_q : len_cnt_q + len_width'(1);
          state_d      = IDLE;
        end else if (len_cnt_q != '1) begin
          len_cnt_d = len_cnt_q + len_width'(1);
        end
      end
    end
    if (scenario_update) begin
      state_d      = IDLE;
      len_cnt_d    = '0;
      frame_len_d  = frame_len_q;
      frame_done_d = 1'b0;
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      len_cnt_q    <= '0;
      frame_len_q  <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      len_cnt_q    <= len_cnt_d;
      frame_len_q  <= frame_len_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

`ifdef LC_SINK_SEQ_CHECK_EN
  logic [PW-1:0] exp_next_q, exp_next_d;
  logic          seq_err_q, seq_err_d;

  // The first packet of a frame arrives in IDLE, so it only seeds the expectation.
  always_comb begin
    exp_next_d = exp_next_q;
    seq_err_d  = seq_err_q;
    if (push) begin
      exp_next_d = pkt_payload + PW'(1);
      if (state_q == RECV && pkt_payload != exp_next_q) seq_err_d = 1'b1;
    end
    if (scenario_update) seq_err_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      exp_next_q <= '0;
      seq_err_q  <= 1'b0;
    end else begin
      exp_next_q <= exp_next_d;
      seq_err_q  <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;
`else
  // Sequence checking is compiled out; no seq_err port exists in this build.
`endif

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign frame_done = frame_done_q;
  assign frame_len  = frame_len_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_lc_packet_sink.sv
// Directed self-checking bench for lc_packet_sink (default 16-bit samples, 4-bit destinations, depth 8).
module tb_lc_packet_sink;

  logic        CLK;
  logic        reset_n;
  logic [37:0] packet_in;
  logic [3:0]  node_mask;
  logic        scenario_update;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  fifo_count;
  logic        frame_done;
  logic [9:0]  frame_len;
  logic        overflow;
  logic [9:0]  drop_count;
`ifdef LC_SINK_SEQ_CHECK_EN
  logic        seq_err;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  lc_packet_sink dut (
    .CLK             (CLK),
    .reset_n         (reset_n),
    .packet_in       (packet_in),
    .node_mask       (node_mask),
    .scenario_update (scenario_update),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .fifo_count      (fifo_count),
    .frame_done      (frame_done),
    .frame_len       (frame_len),
    .overflow        (overflow),
    .drop_count      (drop_count)
`ifdef LC_SINK_SEQ_CHECK_EN
    ,.seq_err        (seq_err)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [37:0] mk_pkt(input logic v, input logic last,
                                         input logic [31:0] pl, input logic [3:0] dest);
    return {v, last, pl, dest};
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_sink;
    packet_in       = '0;
    scenario_update = 1'b1;
    tick;
    scenario_update = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) tick;
    tests_run++;
    if ({out_valid, out_data, fifo_count, frame_done, frame_len, overflow, drop_count} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got v=%b d=%h cnt=%0d fd=%b fl=%0d ov=%b dc=%0d, expected all zero",
               out_valid, out_data, fifo_count, frame_done, frame_len, overflow, drop_count);
    end
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    logic        exp_v;
    logic [31:0] exp_d;
    out_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      exp_d = 32'h100 + 32'(c) - 32'd1;
      if (c <= 5) packet_in = mk_pkt(1'b1, c == 5, exp_d, 4'b0100);
      else        packet_in = '0;
      tick;
      exp_v = (c >= 2 && c <= 6);
      exp_d = 32'h100 + 32'(c) - 32'd2;
      tests_run++;
      if (out_valid !== exp_v) begin
        tests_failed++;
        $display("[TB] FAIL basic_valid c=%0d: got %b expected %b", c, out_valid, exp_v);
      end
      if (exp_v) begin
        tests_run++;
        if (out_data !== exp_d) begin
          tests_failed++;
          $display("[TB] FAIL basic_data c=%0d: got %h expected %h", c, out_data, exp_d);
        end
      end
      tests_run++;
      if (frame_done !== (c == 5)) begin
        tests_failed++;
        $display("[TB] FAIL basic_frame_done c=%0d: got %b expected %b", c, frame_done, c == 5);
      end
    end
    tests_run++;
    if (frame_len !== 10'd5) begin
      tests_failed++;
      $display("[TB] FAIL basic_frame_len: got %0d expected 5", frame_len);
    end
  endtask

  task automatic test_filter;
    out_ready = 1'b1;
    packet_in = mk_pkt(1'b1, 1'b0, 32'h200, 4'b0010);
    tick;
    tests_run++;
    if (fifo_count !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL filter_miss_count: got %0d expected 0", fifo_count);
    end
    packet_in = mk_pkt(1'b1, 1'b1, 32'h201, 4'b0110);
    tick;
    packet_in = '0;
    tests_run++;
    if (fifo_count !== 4'd1 || frame_done !== 1'b1 || frame_len !== 10'd1) begin
      tests_failed++;
      $display("[TB] FAIL filter_hit: got cnt=%0d fd=%b fl=%0d expected cnt=1 fd=1 fl=1",
               fifo_count, frame_done, frame_len);
    end
    tick;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'h201 || fifo_count !== 4'd1) begin
      tests_failed++;
      $display("[TB] FAIL filter_out: got v=%b d=%h cnt=%0d expected v=1 d=00000201 cnt=1",
               out_valid, out_data, fifo_count);
    end
    tick;
    tests_run++;
    if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL filter_drained: got v=%b cnt=%0d expected v=0 cnt=0", out_valid, fifo_count);
    end
  endtask

  task automatic test_overflow;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      packet_in = mk_pkt(1'b1, 1'b0, 32'h300 + 32'(i), 4'b0100);
      tick;
    end
    packet_in = '0;
    tests_run++;
    if (fifo_count !== 4'd8 || overflow !== 1'b1 || drop_count !== 10'd2) begin
      tests_failed++;
      $display("[TB] FAIL overflow_stats: got cnt=%0d ov=%b dc=%0d expected cnt=8 ov=1 dc=2",
               fifo_count, overflow, drop_count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 32'h300 + 32'(i)) begin
        tests_failed++;
        $display("[TB] FAIL overflow_drain i=%0d: got v=%b d=%h expected v=1 d=%h",
                 i, out_valid, out_data, 32'h300 + 32'(i));
      end
      tick;
    end
    tests_run++;
    if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL overflow_empty: got v=%b cnt=%0d expected v=0 cnt=0", out_valid, fifo_count);
    end
  endtask

  task automatic test_full_pop_push;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      packet_in = mk_pkt(1'b1, 1'b0, 32'h400 + 32'(i), 4'b0100);
      tick;
    end
    tests_run++;
    if (fifo_count !== 4'd8 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL fullpp_filled: got cnt=%0d v=%b expected cnt=8 v=1", fifo_count, out_valid);
    end
    out_ready = 1'b1;
    packet_in = mk_pkt(1'b1, 1'b0, 32'h408, 4'b0100);
    tick;
    packet_in = '0;
    tests_run++;
    if (fifo_count !== 4'd8 || drop_count !== 10'd0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fullpp_accept: got cnt=%0d dc=%0d ov=%b expected cnt=8 dc=0 ov=0",
               fifo_count, drop_count, overflow);
    end
    for (int i = 1; i <= 8; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 32'h400 + 32'(i)) begin
        tests_failed++;
        $display("[TB] FAIL fullpp_order i=%0d: got v=%b d=%h expected v=1 d=%h",
                 i, out_valid, out_data, 32'h400 + 32'(i));
      end
      tick;
    end
    tests_run++;
    if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL fullpp_empty: got v=%b cnt=%0d expected v=0 cnt=0", out_valid, fifo_count);
    end
  endtask

  task automatic test_clear;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      packet_in = mk_pkt(1'b1, 1'b0, 32'h500 + 32'(i), 4'b0100);
      tick;
    end
    packet_in = '0;
    tick;
    tests_run++;
    if (fifo_count !== 4'd3 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL clear_queued: got cnt=%0d v=%b expected cnt=3 v=1", fifo_count, out_valid);
    end
    scenario_update = 1'b1;
    packet_in = mk_pkt(1'b1, 1'b1, 32'h5FF, 4'b0100);
    tick;
    scenario_update = 1'b0;
    packet_in = '0;
    tests_run++;
    if (out_valid !== 1'b0 || fifo_count !== 4'd0 || drop_count !== 10'd0 ||
        frame_done !== 1'b0 || frame_len !== 10'd1) begin
      tests_failed++;
      $display("[TB] FAIL clear_state: got v=%b cnt=%0d dc=%0d fd=%b fl=%0d expected v=0 cnt=0 dc=0 fd=0 fl=1",
               out_valid, fifo_count, drop_count, frame_done, frame_len);
    end
    for (int i = 0; i < 9; i++) begin
      packet_in = mk_pkt(1'b1, 1'b0, 32'h510 + 32'(i), 4'b0100);
      tick;
    end
    packet_in = '0;
    tests_run++;
    if (drop_count !== 10'd1 || overflow !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL clear_predrop: got dc=%0d ov=%b expected dc=1 ov=1", drop_count, overflow);
    end
    clear_sink;
    tests_run++;
    if (drop_count !== 10'd0 || overflow !== 1'b0 || fifo_count !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL clear_stats: got dc=%0d ov=%b cnt=%0d expected dc=0 ov=0 cnt=0",
               drop_count, overflow, fifo_count);
    end
    packet_in = mk_pkt(1'b1, 1'b1, 32'h5AA, 4'b0100);
    tick;
    packet_in = '0;
    tests_run++;
    if (frame_done !== 1'b1 || frame_len !== 10'd1) begin
      tests_failed++;
      $display("[TB] FAIL clear_fsm_idle: got fd=%b fl=%0d expected fd=1 fl=1", frame_done, frame_len);
    end
  endtask

  task automatic test_reset_mid_frame;
    clear_sink;
    out_ready = 1'b0;
    packet_in = mk_pkt(1'b1, 1'b0, 32'h600, 4'b0100);
    tick;
    packet_in = mk_pkt(1'b1, 1'b0, 32'h601, 4'b0100);
    tick;
    packet_in = '0;
    tick;
    reset_n = 1'b0;
    #2;
    tests_run++;
    if ({out_valid, out_data, fifo_count, frame_done, frame_len, overflow, drop_count} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_outputs: got v=%b d=%h cnt=%0d fd=%b fl=%0d ov=%b dc=%0d, expected all zero",
               out_valid, out_data, fifo_count, frame_done, frame_len, overflow, drop_count);
    end
    tick;
    reset_n = 1'b1;
    tick;
    tests_run++;
    if (frame_done !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_no_done: got fd=%b v=%b expected fd=0 v=0", frame_done, out_valid);
    end
    packet_in = mk_pkt(1'b1, 1'b1, 32'h602, 4'b0100);
    tick;
    packet_in = '0;
    tests_run++;
    if (frame_done !== 1'b1 || frame_len !== 10'd1) begin
      tests_failed++;
      $display("[TB] FAIL midreset_new_frame: got fd=%b fl=%0d expected fd=1 fl=1", frame_done, frame_len);
    end
    out_ready = 1'b1;
  endtask

`ifdef LC_SINK_SEQ_CHECK_EN
  task automatic test_seq_check;
    clear_sink;
    out_ready = 1'b1;
    packet_in = mk_pkt(1'b1, 1'b0, 32'hFFFFFFFF, 4'b0100);
    tick;
    packet_in = mk_pkt(1'b1, 1'b0, 32'h00000000, 4'b0100);
    tick;
    tests_run++;
    if (seq_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL seq_wrap: got %b expected 0", seq_err);
    end
    packet_in = mk_pkt(1'b1, 1'b1, 32'h00000002, 4'b0100);
    tick;
    packet_in = '0;
    tests_run++;
    if (seq_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL seq_gap: got %b expected 1", seq_err);
    end
  endtask
`endif

  initial begin
    reset_n         = 1'b0;
    packet_in       = '0;
    node_mask       = 4'b0100;
    scenario_update = 1'b0;
    out_ready       = 1'b1;
    test_reset;
    test_basic;
    clear_sink;
    test_filter;
    clear_sink;
    test_overflow;
    clear_sink;
    test_full_pop_push;
    clear_sink;
    test_clear;
    test_reset_mid_frame;
`ifdef LC_SINK_SEQ_CHECK_EN
    test_seq_check;
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lc_packet_sink.md
# lc_packet_sink

Receive-side endpoint for packets emitted on `packet_out` by the local controller ring. It samples the packet bus every cycle and accepts packets whose destination vector selects this node. Accepted sample payloads are buffered in a FIFO and delivered to the downstream consumer (correlator/PE tile) over a valid/ready handshake. Frame boundaries are tracked, and frame-length and drop statistics are reported to the global controller.

## Interface
Parameters:
- `datawidth`, 16, sample component width; payload is `2*datawidth`.
- `address_vector_width`, 4, width of the destination bit-vector.
- `packet_width`, `2 + 2*datawidth + address_vector_width`, packet bus width.
- `fifo_depth`, 8, FIFO entries; must be a power of two, ≥ 2.
- `len_width`, 10, width of the frame-length and drop counters.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `packet_in`  in  `packet_width`  packet bus.
  - [`packet_width`-1] valid.
  - [`packet_width`-2] last-of-frame.
  - [`packet_width`-3:`address_vector_width`] payload.
  - [`address_vector_width`-1:0] destination vector.
- `node_mask`  in  `address_vector_width`  this sink's address bit(s); quasi-static.
- `scenario_update`  in  1  synchronous clear of statistics, FIFO and FSM.
- `out_data`  out  `2*datawidth`  head-of-FIFO payload.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `fifo_count`  out  `$clog2(fifo_depth)+1`  current occupancy.
- `frame_done`  out  1  one-cycle pulse when a frame closes.
- `frame_len`  out  `len_width`  packets in the closed frame; held until the next `frame_done`.
- `overflow`  out  1  sticky: at least one packet was dropped because the FIFO was full.
- `drop_count`  out  `len_width`  saturating count of dropped packets.
- `seq_err`  out  1  sticky sequence error; present only with `LC_SINK_SEQ_CHECK_EN`.

## Operation
- **Match:** `hit = valid & |(dest & node_mask)`. Multicast is supported, since any overlapping bit matches. Non-hits are ignored entirely.
- **Push:** `push = hit & (~full | pop)`, where `pop = out_valid & out_ready`.
- **Drop:** `hit & full & ~pop` drops the packet. It sets `overflow` and increments `drop_count`, saturating at all-ones.
- **FIFO:** circular buffer with read/write pointers one bit wider than the address.
  - `full` when the pointers differ only in the MSB.
  - `empty` when the pointers are equal.
  - Pointers wrap naturally.
  - `out_data` is registered from the head entry.
- **FSM states:** IDLE, RECV.
  - IDLE → RECV on a hit with last=0. `len_cnt` is set to 1.
  - IDLE, hit with last=1: a single-packet frame. Pulse `frame_done`, `frame_len`=1, stay in IDLE.
  - RECV, hit with last=0: `len_cnt`++ (saturating).
  - RECV, hit with last=1: pulse `frame_done`, `frame_len`=`len_cnt`+1 (saturating), go to IDLE.
  - Dropped hits still count toward frame length and still close frames.
- **`scenario_update`:** highest priority. In one cycle it:
  - empties the FIFO;
  - sends the FSM to IDLE;
  - clears `len_cnt`, `overflow`, `drop_count` and `seq_err`;
  - leaves `frame_len` unchanged.
  - Any packet present in that cycle is discarded.
- **Reset:** all of the following go to 0 asynchronously: `out_valid`, `out_data`, `fifo_count`, `frame_done`, `frame_len`, `overflow`, `drop_count`, `seq_err`. FSM = IDLE, pointers = 0.
- **Reset mid-frame:** abandons the frame with no `frame_done`.

## Timing
- A hit sampled at edge N is written at edge N. With the FIFO previously empty, `out_valid`=1 after edge N+1 (2-cycle latency).
- `out_data`/`out_valid` change only on clock edges and hold stable while `out_valid & ~out_ready`.
- Full FIFO with a pop and a hit in the same cycle: the hit is accepted and `fifo_count` is unchanged.
- `frame_done` is asserted the cycle after the last packet is sampled, for exactly one cycle.
- `fifo_count` reflects pushes and pops registered at the preceding edge.

## Configuration
- Macro `LC_SINK_SEQ_CHECK_EN`.
- **Defined:** the block keeps `exp_next`, which is loaded with payload+1 on every push.
  - `exp_next` is valid from the second push of a frame onward.
  - On a push inside RECV where payload ≠ `exp_next` (modulo 2^(2*datawidth)), `seq_err` sets sticky.
  - The frame's first packet always reloads `exp_next`.
- **Undefined:** the `seq_err` port and its logic are absent.

## Test plan
- **Basic delivery.** Stimulus: `node_mask`=0100, `out_ready`=1; 5 packets, valid=1, dest=0100, payloads 0x100..0x104, last=1 on the fifth. Response:
  - `out_data` 0x100..0x104 in order, first `out_valid` 2 cycles after the first packet;
  - `frame_done` pulse with `frame_len`=5.
- **Filtering/multicast.** Stimulus: dest=0010 (miss), then dest=0110 (hit). Response: only the second packet appears and `fifo_count` peaks at 1.
- **Overflow.** Stimulus: `out_ready`=0, `fifo_depth`=8, 10 hits. Response:
  - `fifo_count`=8, `overflow`=1, `drop_count`=2;
  - after `out_ready`=1, exactly the first 8 payloads drain.
- **Full with simultaneous pop and push.** Stimulus: FIFO at 8, `out_ready`=1, a hit in the same cycle. Response: packet accepted, `fifo_count` stays 8, `drop_count` unchanged.
- **Clear and reset.** Stimulus: `scenario_update` mid-frame with 3 entries queued. Response:
  - next cycle `out_valid`=0, `fifo_count`=0, `drop_count`=0;
  - `reset_n` low mid-frame forces all outputs to 0 with no `frame_done`.
- **Sequence check (macro defined).** Stimulus: payloads 0xFFFFFFFF, 0x00000000, 0x00000002. Response:
  - wrap from 0xFFFFFFFF to 0x00000000 is accepted without error;
  - `seq_err`=1 after the third push.
